// File: rtl/updown_counter_mod_if.sv
// Control and status bundle for updown_counter_mod.
// master drives the controls and observes the count; slave is the counter itself.
interface updown_counter_mod_if #(
   parameter int WIDTH = 8
);
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             enable;
   logic             up_down;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_zero;
   logic             wrap;
   logic             sat_hit;

   modport master (
      output clear, load, load_value, enable, up_down,
      input  count, at_max, at_zero, wrap, sat_hit
   );

   modport slave (
      input  clear, load, load_value, enable, up_down,
      output count, at_max, at_zero, wrap, sat_hit
   );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter over 0..MOD-1 with wrap or saturate mode,
// synchronous clear/load and registered wrap/sat_hit event pulses.
module updown_counter_mod #(
   parameter int              WIDTH    = 8,
   parameter longint unsigned MOD      = 256,
   parameter bit              SATURATE = 1'b0
) (
   input logic                 clk,
   input logic                 reset_n,
   updown_counter_mod_if.slave bus
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "updown_counter_mod: WIDTH must be 2..32");
   end
   if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
      $fatal(1, "updown_counter_mod: MOD must be 2..2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 64'd1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             sat_hit_q, sat_hit_d;

   // Range ends are tested before stepping, so count never leaves 0..MAX.
   always_comb begin
      count_d   = count_q;
      wrap_d    = 1'b0;
      sat_hit_d = 1'b0;
      if (bus.clear) begin
         count_d = '0;
      end else if (bus.load) begin
         count_d = (bus.load_value > MAX) ? MAX : bus.load_value;
      end else if (bus.enable) begin
         if (bus.up_down) begin
            if (count_q < MAX) begin
               count_d = count_q + WIDTH'(1);
            end else if (SATURATE) begin
               sat_hit_d = 1'b1;
            end else begin
               count_d = '0;
               wrap_d  = 1'b1;
            end
         end else begin
            if (count_q != '0) begin
               count_d = count_q - WIDTH'(1);
            end else if (SATURATE) begin
               sat_hit_d = 1'b1;
            end else begin
               count_d = MAX;
               wrap_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         wrap_q    <= 1'b0;
         sat_hit_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrap_q    <= wrap_d;
         sat_hit_q <= sat_hit_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.wrap    = wrap_q;
   assign bus.sat_hit = sat_hit_q;
   assign bus.at_max  = (count_q == MAX);
   assign bus.at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: three configurations (256/wrap,
// 10/wrap, 10/saturate) share one stimulus stream and a scoreboard queue.
module tb_updown_counter_mod;

   localparam int NI = 3;
   localparam int MODS[NI] = '{256, 10, 10};
   localparam bit SATS[NI] = '{1'b0, 1'b0, 1'b1};

   typedef struct {
      string           tag;
      logic [2:0][7:0] cnt;
      logic [2:0]      wr;
      logic [2:0]      sh;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0, load = 1'b0, enable = 1'b0, up_down = 1'b0;
   logic [7:0] load_value = '0;

   int   total = 0;
   int   bad = 0;
   int   m_cnt[NI];
   exp_t sb[$];

   always #5 clk = ~clk;

   updown_counter_mod_if #(.WIDTH(8)) u0 ();
   updown_counter_mod_if #(.WIDTH(8)) u1 ();
   updown_counter_mod_if #(.WIDTH(8)) u2 ();

   updown_counter_mod #(.WIDTH(8), .MOD(256), .SATURATE(1'b0)) dut_a (
      .clk(clk), .reset_n(rst_n), .bus(u0));
   updown_counter_mod #(.WIDTH(8), .MOD(10), .SATURATE(1'b0)) dut_b (
      .clk(clk), .reset_n(rst_n), .bus(u1));
   updown_counter_mod #(.WIDTH(8), .MOD(10), .SATURATE(1'b1)) dut_c (
      .clk(clk), .reset_n(rst_n), .bus(u2));

   assign u0.clear = clear;   assign u1.clear = clear;   assign u2.clear = clear;
   assign u0.load = load;     assign u1.load = load;     assign u2.load = load;
   assign u0.enable = enable; assign u1.enable = enable; assign u2.enable = enable;
   assign u0.up_down = up_down; assign u1.up_down = up_down; assign u2.up_down = up_down;
   assign u0.load_value = load_value;
   assign u1.load_value = load_value;
   assign u2.load_value = load_value;

   logic [7:0] o_cnt[NI];
   logic       o_wr[NI], o_sh[NI], o_max[NI], o_zero[NI];
   assign o_cnt[0] = u0.count; assign o_cnt[1] = u1.count; assign o_cnt[2] = u2.count;
   assign o_wr[0] = u0.wrap;   assign o_wr[1] = u1.wrap;   assign o_wr[2] = u2.wrap;
   assign o_sh[0] = u0.sat_hit; assign o_sh[1] = u1.sat_hit; assign o_sh[2] = u2.sat_hit;
   assign o_max[0] = u0.at_max; assign o_max[1] = u1.at_max; assign o_max[2] = u2.at_max;
   assign o_zero[0] = u0.at_zero; assign o_zero[1] = u1.at_zero; assign o_zero[2] = u2.at_zero;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of one edge for every configuration.
   task automatic model(input logic c, l, e, ud, input logic [7:0] lv, inout exp_t x);
      for (int i = 0; i < NI; i++) begin
         x.wr[i] = 1'b0;
         x.sh[i] = 1'b0;
         if (c) m_cnt[i] = 0;
         else if (l) m_cnt[i] = (int'(lv) > MODS[i] - 1) ? MODS[i] - 1 : int'(lv);
         else if (e && ud) begin
            if (m_cnt[i] == MODS[i] - 1) begin
               if (SATS[i]) x.sh[i] = 1'b1;
               else begin m_cnt[i] = 0; x.wr[i] = 1'b1; end
            end else m_cnt[i]++;
         end else if (e) begin
            if (m_cnt[i] == 0) begin
               if (SATS[i]) x.sh[i] = 1'b1;
               else begin m_cnt[i] = MODS[i] - 1; x.wr[i] = 1'b1; end
            end else m_cnt[i]--;
         end
         x.cnt[i] = 8'(m_cnt[i]);
      end
   endtask

   task automatic compare(input exp_t x);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s.cnt%0d", x.tag, i), 32'(o_cnt[i]), 32'(x.cnt[i]));
         chk($sformatf("%s.wrap%0d", x.tag, i), 32'(o_wr[i]), 32'(x.wr[i]));
         chk($sformatf("%s.sat%0d", x.tag, i), 32'(o_sh[i]), 32'(x.sh[i]));
         chk($sformatf("%s.max%0d", x.tag, i), 32'(o_max[i]), 32'(x.cnt[i] == 8'(MODS[i] - 1)));
         chk($sformatf("%s.zero%0d", x.tag, i), 32'(o_zero[i]), 32'(x.cnt[i] == 8'd0));
      end
   endtask

   task automatic step(input string tag, input logic c, l, e, ud, input logic [7:0] lv);
      exp_t x;
      clear = c; load = l; enable = e; up_down = ud; load_value = lv;
      x.tag = tag;
      model(c, l, e, ud, lv, x);
      sb.push_back(x);
      @(posedge clk);
      #1;
      compare(sb.pop_front());
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < NI; i++) begin
         m_cnt[i] = 0;
         chk($sformatf("%s.cnt%0d", tag, i), 32'(o_cnt[i]), 32'd0);
         chk($sformatf("%s.zero%0d", tag, i), 32'(o_zero[i]), 32'd1);
         chk($sformatf("%s.max%0d", tag, i), 32'(o_max[i]), 32'd0);
         chk($sformatf("%s.wrap%0d", tag, i), 32'(o_wr[i]), 32'd0);
         chk($sformatf("%s.sat%0d", tag, i), 32'(o_sh[i]), 32'd0);
      end
   endtask

   initial begin
      int wraps;
      #2;
      check_reset("por");
      #10 rst_n = 1'b1;                       // released mid-cycle at t=12

      // Mid-cycle asynchronous reset with a nonzero count.
      step("ld37", 1'b0, 1'b1, 1'b0, 1'b0, 8'h37);
      #3 rst_n = 1'b0;
      #1 check_reset("arst");
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) step($sformatf("up%0d", k), 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

      // Modulo wrap up and down.
      step("clr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step("ld9", 1'b0, 1'b1, 1'b0, 1'b0, 8'd9);
      step("wrap_up", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      step("wrap_dn", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

      // 25 up steps from 0: MOD=10 wraps twice and ends at 5.
      step("clr25", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      wraps = 0;
      for (int k = 0; k < 25; k++) begin
         step($sformatf("run%0d", k), 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
         if (o_wr[1] === 1'b1) wraps++;
      end
      chk("run.wraps", 32'(wraps), 32'd2);
      chk("run.final", 32'(o_cnt[1]), 32'd5);

      // Saturation at top and bottom.
      step("ld8", 1'b0, 1'b1, 1'b0, 1'b0, 8'd8);
      for (int k = 0; k < 3; k++) step($sformatf("sat_up%0d", k), 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      step("clr_s", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step("sat_dn", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step("sat_dn2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

      // Priority clear > load > enable.
      step("prio_clr", 1'b1, 1'b1, 1'b1, 1'b1, 8'd5);
      step("prio_ld", 1'b0, 1'b1, 1'b1, 1'b1, 8'd5);

      // Load clamp and hold.
      step("ld200", 1'b0, 1'b1, 1'b0, 1'b0, 8'd200);
      for (int k = 0; k < 4; k++) step($sformatf("hold%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("clamp.cnt_b", 32'(o_cnt[1]), 32'd9);

      // Direction toggle every cycle.
      step("ld80", 1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
      for (int k = 0; k < 6; k++) step($sformatf("tog%0d", k), 1'b0, 1'b0, 1'b1, (k % 2 == 0), 8'h00);
      chk("tog.final_a", 32'(o_cnt[0]), 32'h80);

      // Asynchronous reset cancels a pending wrap / sat_hit pulse.
      step("clr_p", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step("pend", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      #2 rst_n = 1'b0;
      #1 check_reset("cancel");
      #2 rst_n = 1'b1;

      // Mixed traffic.
      for (int k = 0; k < 60; k++) begin
         step($sformatf("rnd%0d", k), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
